hazard_unit: RTL and testbench

Pipeline hazard tracker and forwarding-select generator for the five-stage MIPS core. It consumes the per-instruction use/produce classification that the D-stage decoder emits and carries each in-flight destination register and its remaining produce latency through E, M and W. From that state it raises `stall` and drives the forwarding-mux selects for the D, E and M stages.

---
 rtl/hazard_unit.sv | 141 ++++++++++++++
 tb/tb_hazard_unit.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Hazard tracker and forwarding-select generator for the five-stage MIPS core.
// Tracks destination/Tnew of the instructions in E, M and W and derives stall and mux selects.
module hazard_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [4:0] d_a3,
    input  logic       d_we,
    input  logic       d_rs_use0,
    input  logic       d_rt_use0,
    input  logic       d_rs_use1,
    input  logic       d_rt_use1,
    input  logic       d_new_e,
    input  logic       d_new_m,
    output logic       stall,
    output logic [1:0] fwd_d_rs,
    output logic [1:0] fwd_d_rt,
    output logic [1:0] fwd_e_rs,
    output logic [1:0] fwd_e_rt,
    output logic [1:0] fwd_m_rt
);

    localparam logic [1:0] FWD_NONE = 2'd0;
    localparam logic [1:0] FWD_E    = 2'd1;
    localparam logic [1:0] FWD_M    = 2'd2;
    localparam logic [1:0] FWD_W    = 2'd3;

    logic [4:0] r_e_a3;
    logic [1:0] r_e_tnew;
    logic [4:0] r_e_rs;
    logic [4:0] r_e_rt;
    logic [4:0] r_m_a3;
    logic [1:0] r_m_tnew;
    logic [4:0] r_m_rt;
    logic [4:0] r_w_a3;

    logic [4:0] w_d_a3;
    logic [1:0] w_d_tnew;
    logic [1:0] w_m_tnew_next;
    logic       w_rs_stall;
    logic       w_rt_stall;

    // A destination of $0 is folded to 0 here so it can never match a consumer later.
    assign w_d_a3        = (d_we && (d_a3 != 5'd0)) ? d_a3 : 5'd0;
    assign w_d_tnew      = d_new_m ? 2'd2 : (d_new_e ? 2'd1 : 2'd0);
    assign w_m_tnew_next = (r_e_tnew == 2'd0) ? 2'd0 : (r_e_tnew - 2'd1);

    function automatic logic operandStall(
        input logic [4:0] addr,
        input logic       use0,
        input logic       use1,
        input logic [4:0] eA3,
        input logic [1:0] eTnew,
        input logic [4:0] mA3,
        input logic [1:0] mTnew
    );
        logic [1:0] tuse;
        logic       hitE;
        logic       hitM;
        tuse = use0 ? 2'd0 : 2'd1;
        hitE = (eA3 == addr) && (eTnew > tuse);
        hitM = (mA3 == addr) && (mTnew > tuse);
        return (use0 || use1) && (addr != 5'd0) && (hitE || hitM);
    endfunction

    // Nearest matching stage decides; a match that is not yet ready blocks older stages.
    function automatic logic [1:0] srcSelect(
        input logic [4:0] addr,
        input logic       eValid,
        input logic [4:0] eA3,
        input logic [1:0] eTnew,
        input logic       mValid,
        input logic [4:0] mA3,
        input logic [1:0] mTnew,
        input logic [4:0] wA3
    );
        logic [1:0] sel;
        sel = FWD_NONE;
        if (addr == 5'd0) begin
            sel = FWD_NONE;
        end else if (eValid && (eA3 == addr)) begin
            sel = (eTnew == 2'd0) ? FWD_E : FWD_NONE;
        end else if (mValid && (mA3 == addr)) begin
            sel = (mTnew == 2'd0) ? FWD_M : FWD_NONE;
        end else if (wA3 == addr) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

    assign w_rs_stall = operandStall(d_rs, d_rs_use0, d_rs_use1,
                                     r_e_a3, r_e_tnew, r_m_a3, r_m_tnew);
    assign w_rt_stall = operandStall(d_rt, d_rt_use0, d_rt_use1,
                                     r_e_a3, r_e_tnew, r_m_a3, r_m_tnew);

    always_comb begin
        stall    = w_rs_stall || w_rt_stall;
        fwd_d_rs = srcSelect(d_rs, 1'b1, r_e_a3, r_e_tnew,
                             1'b1, r_m_a3, r_m_tnew, r_w_a3);
        fwd_d_rt = srcSelect(d_rt, 1'b1, r_e_a3, r_e_tnew,
                             1'b1, r_m_a3, r_m_tnew, r_w_a3);
        fwd_e_rs = srcSelect(r_e_rs, 1'b0, 5'd0, 2'd0,
                             1'b1, r_m_a3, r_m_tnew, r_w_a3);
        fwd_e_rt = srcSelect(r_e_rt, 1'b0, 5'd0, 2'd0,
                             1'b1, r_m_a3, r_m_tnew, r_w_a3);
        fwd_m_rt = srcSelect(r_m_rt, 1'b0, 5'd0, 2'd0,
                             1'b0, 5'd0, 2'd0, r_w_a3);
    end

    // A stall turns the E slot into a bubble while M and W keep draining.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_e_a3   <= 5'd0;
            r_e_tnew <= 2'd0;
            r_e_rs   <= 5'd0;
            r_e_rt   <= 5'd0;
            r_m_a3   <= 5'd0;
            r_m_tnew <= 2'd0;
            r_m_rt   <= 5'd0;
            r_w_a3   <= 5'd0;
        end else begin
            if (stall) begin
                r_e_a3   <= 5'd0;
                r_e_tnew <= 2'd0;
                r_e_rs   <= 5'd0;
                r_e_rt   <= 5'd0;
            end else begin
                r_e_a3   <= w_d_a3;
                r_e_tnew <= w_d_tnew;
                r_e_rs   <= d_rs;
                r_e_rt   <= d_rt;
            end
            r_m_a3   <= r_e_a3;
            r_m_tnew <= w_m_tnew_next;
            r_m_rt   <= r_e_rt;
            r_w_a3   <= r_m_a3;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: reference model tracks in-flight instructions by the
// absolute cycle their result becomes ready, plus hand-derived directed sequences.
module tb_hazard_unit;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] a3;
        logic       we;
        logic       u0s;
        logic       u0t;
        logic       u1s;
        logic       u1t;
        logic       ne;
        logic       nm;
    } instr_t;

    typedef struct {
        logic [4:0] dest;
        int         readyAt;
        logic [4:0] rs;
        logic [4:0] rt;
    } rec_t;

    typedef struct {
        int         cyc;
        logic       stall;
        logic [1:0] fdrs;
        logic [1:0] fdrt;
        logic [1:0] fers;
        logic [1:0] fert;
        logic [1:0] fmrt;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] d_rs = '0;
    logic [4:0] d_rt = '0;
    logic [4:0] d_a3 = '0;
    logic       d_we = 1'b0;
    logic       d_rs_use0 = 1'b0;
    logic       d_rt_use0 = 1'b0;
    logic       d_rs_use1 = 1'b0;
    logic       d_rt_use1 = 1'b0;
    logic       d_new_e = 1'b0;
    logic       d_new_m = 1'b0;
    logic       stall;
    logic [1:0] fwd_d_rs;
    logic [1:0] fwd_d_rt;
    logic [1:0] fwd_e_rs;
    logic [1:0] fwd_e_rt;
    logic [1:0] fwd_m_rt;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   armed = 1'b0;
    logic lastStall = 1'b0;
    rec_t pipe[$];
    exp_t sb[$];

    hazard_unit dut (
        .clk      (clk),
        .reset    (reset),
        .d_rs     (d_rs),
        .d_rt     (d_rt),
        .d_a3     (d_a3),
        .d_we     (d_we),
        .d_rs_use0(d_rs_use0),
        .d_rt_use0(d_rt_use0),
        .d_rs_use1(d_rs_use1),
        .d_rt_use1(d_rt_use1),
        .d_new_e  (d_new_e),
        .d_new_m  (d_new_m),
        .stall    (stall),
        .fwd_d_rs (fwd_d_rs),
        .fwd_d_rt (fwd_d_rt),
        .fwd_e_rs (fwd_e_rs),
        .fwd_e_rt (fwd_e_rt),
        .fwd_m_rt (fwd_m_rt)
    );

    always #5 clk = ~clk;

    function automatic instr_t mk(input int rs, input int rt, input int a3, input bit we,
                                  input bit u0s, input bit u0t, input bit u1s, input bit u1t,
                                  input bit ne, input bit nm);
        instr_t i;
        i.rs = 5'(rs); i.rt = 5'(rt); i.a3 = 5'(a3); i.we = we;
        i.u0s = u0s; i.u0t = u0t; i.u1s = u1s; i.u1t = u1t; i.ne = ne; i.nm = nm;
        return i;
    endfunction

    function automatic rec_t bubble();
        rec_t r;
        r.dest = 5'd0; r.readyAt = 0; r.rs = 5'd0; r.rt = 5'd0;
        return r;
    endfunction

    // pipe[2] is the instruction in E, pipe[1] in M, pipe[0] in W.
    function automatic void modelReset();
        pipe.delete();
        for (int k = 0; k < 3; k++) pipe.push_back(bubble());
    endfunction

    function automatic logic needsStall(input logic [4:0] addr, input int tuse);
        logic s;
        s = 1'b0;
        if (addr != 5'd0 && tuse >= 0)
            for (int age = 0; age < 2; age++)
                if (pipe[2-age].dest == addr && pipe[2-age].readyAt > cyc + tuse) s = 1'b1;
        return s;
    endfunction

    function automatic logic [1:0] pickSource(input logic [4:0] addr, input int fromAge);
        if (addr == 5'd0) return 2'd0;
        for (int age = fromAge; age < 3; age++)
            if (pipe[2-age].dest == addr)
                return (pipe[2-age].readyAt <= cyc) ? 2'(age + 1) : 2'd0;
        return 2'd0;
    endfunction

    task automatic applyStimulus(input logic rst, input instr_t ins);
        exp_t e;
        rec_t r;
        int   tuseRs;
        int   tuseRt;
        @(posedge clk);
        #1;
        reset = rst; d_rs = ins.rs; d_rt = ins.rt; d_a3 = ins.a3; d_we = ins.we;
        d_rs_use0 = ins.u0s; d_rt_use0 = ins.u0t; d_rs_use1 = ins.u1s; d_rt_use1 = ins.u1t;
        d_new_e = ins.ne; d_new_m = ins.nm;
        tuseRs = ins.u0s ? 0 : (ins.u1s ? 1 : -1);
        tuseRt = ins.u0t ? 0 : (ins.u1t ? 1 : -1);
        e.cyc   = cyc;
        e.stall = needsStall(ins.rs, tuseRs) || needsStall(ins.rt, tuseRt);
        e.fdrs  = pickSource(ins.rs, 0);
        e.fdrt  = pickSource(ins.rt, 0);
        e.fers  = pickSource(pipe[2].rs, 1);
        e.fert  = pickSource(pipe[2].rt, 1);
        e.fmrt  = pickSource(pipe[1].rt, 2);
        if (armed) sb.push_back(e);
        lastStall = e.stall;
        if (!rst) begin
            modelReset();
        end else begin
            r = bubble();
            if (!e.stall) begin
                r.dest    = (ins.we && ins.a3 != 5'd0) ? ins.a3 : 5'd0;
                r.readyAt = cyc + 1 + (ins.nm ? 2 : (ins.ne ? 1 : 0));
                r.rs      = ins.rs;
                r.rt      = ins.rt;
            end
            pipe.push_back(r);
            void'(pipe.pop_front());
        end
        cyc++;
    endtask

    task automatic compare(input string name, input int c, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d actual=%0d required=%0d", name, c, act, req);
        end
    endtask

    task automatic checkOutput(input string name, input logic s, input logic [1:0] fdrs,
                               input logic [1:0] fdrt, input logic [1:0] fers,
                               input logic [1:0] fert, input logic [1:0] fmrt);
        @(negedge clk);
        compare({name, ".stall"}, cyc, int'(stall), int'(s));
        compare({name, ".fwd_d_rs"}, cyc, int'(fwd_d_rs), int'(fdrs));
        compare({name, ".fwd_d_rt"}, cyc, int'(fwd_d_rt), int'(fdrt));
        compare({name, ".fwd_e_rs"}, cyc, int'(fwd_e_rs), int'(fers));
        compare({name, ".fwd_e_rt"}, cyc, int'(fwd_e_rt), int'(fert));
        compare({name, ".fwd_m_rt"}, cyc, int'(fwd_m_rt), int'(fmrt));
    endtask

    // Scoreboard monitor: outputs are combinational, so one response is due every cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            compare("sb.stall", e.cyc, int'(stall), int'(e.stall));
            compare("sb.fwd_d_rs", e.cyc, int'(fwd_d_rs), int'(e.fdrs));
            compare("sb.fwd_d_rt", e.cyc, int'(fwd_d_rt), int'(e.fdrt));
            compare("sb.fwd_e_rs", e.cyc, int'(fwd_e_rs), int'(e.fers));
            compare("sb.fwd_e_rt", e.cyc, int'(fwd_e_rt), int'(e.fert));
            compare("sb.fwd_m_rt", e.cyc, int'(fwd_m_rt), int'(e.fmrt));
        end
    end

    function automatic logic [4:0] randReg();
        int k;
        k = $urandom_range(0, 5);
        return (k == 5) ? 5'd31 : 5'(k);
    endfunction

    function automatic instr_t randInstr();
        return mk(int'(randReg()), int'(randReg()), int'(randReg()), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
    endfunction

    task automatic doReset(input instr_t ins);
        applyStimulus(1'b0, ins);
        applyStimulus(1'b0, ins);
    endtask

    instr_t nop, lw8, add98, beq8, ori4, beq44, jal, jr31, add0, beq00, add3, sw3;
    instr_t ori6, lw6, use6, rst5;

    initial begin
        nop   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        lw8   = mk(2, 8, 8, 1, 0, 0, 1, 0, 0, 1);
        add98 = mk(8, 1, 9, 1, 0, 0, 1, 1, 1, 0);
        beq8  = mk(8, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        ori4  = mk(0, 4, 4, 1, 0, 0, 1, 0, 1, 0);
        beq44 = mk(4, 4, 0, 0, 1, 1, 0, 0, 0, 0);
        jal   = mk(0, 0, 31, 1, 0, 0, 0, 0, 0, 0);
        jr31  = mk(31, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add0  = mk(1, 2, 0, 1, 0, 0, 1, 1, 1, 0);
        beq00 = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        add3  = mk(1, 1, 3, 1, 0, 0, 1, 1, 1, 0);
        sw3   = mk(2, 3, 0, 0, 0, 0, 1, 0, 0, 0);
        ori6  = mk(0, 6, 6, 1, 0, 0, 1, 0, 1, 0);
        lw6   = mk(0, 6, 6, 1, 0, 0, 1, 0, 0, 1);
        use6  = mk(6, 6, 7, 1, 0, 0, 1, 0, 1, 0);
        rst5  = mk(5, 0, 0, 0, 1, 0, 0, 0, 0, 0);

        modelReset();
        doReset(nop);
        armed = 1'b1;

        $display("[TB] reset clears in-flight producer");
        applyStimulus(1'b1, mk(0, 5, 5, 1, 0, 0, 1, 0, 0, 1));
        applyStimulus(1'b0, rst5);
        applyStimulus(1'b0, rst5);
        checkOutput("reset_hold", 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b1, rst5);
        checkOutput("reset_after", 0, 0, 0, 0, 0, 0);

        $display("[TB] lw then Tuse-1 consumer");
        doReset(nop);
        applyStimulus(1'b1, lw8);
        applyStimulus(1'b1, add98);
        checkOutput("lw_add_stall", 1, 0, 0, 0, 0, 0);
        applyStimulus(1'b1, add98);
        checkOutput("lw_add_go", 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b1, nop);
        checkOutput("lw_add_e_fwd", 0, 0, 0, 3, 0, 0);

        $display("[TB] lw then beq");
        doReset(nop);
        applyStimulus(1'b1, lw8);
        applyStimulus(1'b1, beq8);
        checkOutput("lw_beq_s1", 1, 0, 0, 0, 0, 0);
        applyStimulus(1'b1, beq8);
        checkOutput("lw_beq_s2", 1, 0, 0, 0, 0, 0);
        applyStimulus(1'b1, beq8);
        checkOutput("lw_beq_fwd", 0, 3, 0, 0, 0, 0);

        $display("[TB] ori then beq");
        doReset(nop);
        applyStimulus(1'b1, ori4);
        applyStimulus(1'b1, beq44);
        checkOutput("ori_beq_s", 1, 0, 0, 0, 0, 0);
        applyStimulus(1'b1, beq44);
        checkOutput("ori_beq_fwd", 0, 2, 2, 0, 0, 0);

        $display("[TB] jal/jr and $0 destination");
        doReset(nop);
        applyStimulus(1'b1, jal);
        applyStimulus(1'b1, jr31);
        checkOutput("jal_jr", 0, 1, 0, 0, 0, 0);
        doReset(nop);
        applyStimulus(1'b1, add0);
        applyStimulus(1'b1, beq00);
        checkOutput("zero_dest", 0, 0, 0, 0, 0, 0);

        $display("[TB] add then sw");
        doReset(nop);
        applyStimulus(1'b1, add3);
        applyStimulus(1'b1, sw3);
        checkOutput("add_sw_d", 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b1, nop);
        checkOutput("add_sw_e", 0, 0, 0, 0, 2, 0);
        applyStimulus(1'b1, nop);
        checkOutput("add_sw_m", 0, 0, 0, 0, 0, 3);

        $display("[TB] E match shadows ready M match");
        doReset(nop);
        applyStimulus(1'b1, ori6);
        applyStimulus(1'b1, lw6);
        applyStimulus(1'b1, use6);
        checkOutput("e_wins", 1, 0, 0, 0, 2, 0);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 1500; n++) begin
            instr_t ins;
            ins = randInstr();
            for (int k = 0; k < 4; k++) begin
                logic r;
                r = ($urandom_range(0, 59) != 0);
                applyStimulus(r, ins);
                if (!lastStall) break;
            end
        end

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain pending=%0d required=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
